// File: rtl/tone_sequencer.sv
// tone_sequencer: live/timed tone selector with built-in square-wave generator
module tone_sequencer #(
  parameter int N_CH = 4,
  parameter int FREQ_W = 10,
  parameter logic [N_CH*FREQ_W-1:0] TONE_TABLE = {10'd587, 10'd523, 10'd494, 10'd440},
  parameter int CLK_HZ = 50_000_000,
  parameter int TICK_HZ = 1000,
  parameter int DUR_W = 12,
  parameter int GAP_TICKS = 50
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_CH-1:0]         led_color,
  input  logic                    play_valid,
  output logic                    play_ready,
  input  logic [$clog2(N_CH)-1:0] play_ch,
  input  logic [DUR_W-1:0]        play_dur,
  output logic                    done,
  output logic                    sound,
  output logic                    tone_on,
  output logic [FREQ_W-1:0]       frequency
);
  localparam int CW = $clog2(N_CH);
  localparam int TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int GW = $clog2(GAP_TICKS + 1);
  localparam int NW = (GW > DUR_W) ? GW : DUR_W;
  localparam int HW = $clog2(CLK_HZ / 2 + 1);

  function automatic logic [N_CH*HW-1:0] half_table();
    logic [N_CH*HW-1:0] t;
    int f, h;
    t = '0;
    for (int i = 0; i < N_CH; i++) begin
      f = int'(TONE_TABLE[i*FREQ_W +: FREQ_W]);
      h = (f == 0) ? 1 : CLK_HZ / (2 * f);
      t[i*HW +: HW] = HW'((h < 1) ? 1 : h);
    end
    return t;
  endfunction

  localparam logic [N_CH*HW-1:0] HALF_TBL = half_table();

  typedef enum logic [1:0] {IDLE, LIVE, PLAY, GAP} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     pch_q, pch_d, tone_ch_q, tone_ch_d, live_ch;
  logic [DUR_W-1:0]  dur_q, dur_d;
  logic [TW-1:0]     tick_q, tick_d;
  logic [NW-1:0]     ticks_q, ticks_d;
  logic [HW-1:0]     half_cnt_q, half_cnt_d, half_sel;
  logic [FREQ_W-1:0] freq_q, freq_d, freq_sel;
  logic              sound_q, sound_d, tone_on_q, tone_on_d, done_q, done_d, ready_q, ready_d;
  logic              accept, tick_wrap, play_end, gap_end, half_wrap, restart;

  // next state, note timing and registered-output values
  always_comb begin
    live_ch = '0;
    for (int i = N_CH - 1; i >= 0; i--) if (led_color[i]) live_ch = CW'(i);
    accept = play_valid && ready_q;
    tick_wrap = tick_q == TW'(TICK_DIV - 1);
    play_end = (dur_q == '0) || (tick_wrap && ticks_q == NW'(dur_q) - NW'(1));
    gap_end = tick_wrap && ticks_q == NW'(GAP_TICKS - 1);
    state_d = state_q;
    pch_d = pch_q;
    dur_d = dur_q;
    tick_d = tick_wrap ? '0 : tick_q + TW'(1);
    ticks_d = tick_wrap ? ticks_q + NW'(1) : ticks_q;
    done_d = 1'b0;
    case (state_q)
      IDLE, LIVE: begin
        state_d = accept ? PLAY : (|led_color) ? LIVE : IDLE;
        pch_d = accept ? play_ch : pch_q;
        dur_d = accept ? play_dur : dur_q;
        tick_d = '0;
        ticks_d = '0;
      end
      PLAY: if (play_end) begin
        state_d = (GAP_TICKS == 0) ? IDLE : GAP;
        done_d = 1'b1;
        tick_d = '0;
        ticks_d = '0;
      end
      default: if (gap_end) begin
        state_d = IDLE;
        tick_d = '0;
        ticks_d = '0;
      end
    endcase
    tone_ch_d = (state_d == PLAY) ? pch_d : live_ch;
    freq_sel = TONE_TABLE[tone_ch_d*FREQ_W +: FREQ_W];
    half_sel = HALF_TBL[tone_ch_d*HW +: HW];
    tone_on_d = (freq_sel != '0) && (state_d == LIVE || (state_d == PLAY && dur_d != '0));
    freq_d = tone_on_d ? freq_sel : '0;
    restart = !tone_on_q || tone_ch_d != tone_ch_q || accept;
    half_wrap = half_cnt_q == half_sel - HW'(1);
    half_cnt_d = (!tone_on_d || restart || half_wrap) ? '0 : half_cnt_q + HW'(1);
    sound_d = tone_on_d && !restart && (sound_q ^ half_wrap);
    ready_d = state_d == IDLE || state_d == LIVE;
  end

  // state and output registers; ready is high straight out of reset
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      pch_q <= '0;
      tone_ch_q <= '0;
      dur_q <= '0;
      tick_q <= '0;
      ticks_q <= '0;
      half_cnt_q <= '0;
      freq_q <= '0;
      sound_q <= 1'b0;
      tone_on_q <= 1'b0;
      done_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      pch_q <= pch_d;
      tone_ch_q <= tone_ch_d;
      dur_q <= dur_d;
      tick_q <= tick_d;
      ticks_q <= ticks_d;
      half_cnt_q <= half_cnt_d;
      freq_q <= freq_d;
      sound_q <= sound_d;
      tone_on_q <= tone_on_d;
      done_q <= done_d;
      ready_q <= ready_d;
    end

  assign play_ready = ready_q;
  assign done = done_q;
  assign sound = sound_q;
  assign tone_on = tone_on_q;
  assign frequency = freq_q;
endmodule

// File: tb/tb_tone_sequencer.sv
// tb_tone_sequencer: table, directed and randomized checks against a behavioural model
module tb_tone_sequencer;
  localparam int DUR_W = 12;
  localparam int CLK_HZ = 100_000;
  localparam int TICK_HZ = 1000;
  localparam int GAP_TICKS = 2;
  localparam int DIV = CLK_HZ / TICK_HZ;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [3:0] led_color = '0;
  logic play_valid = 1'b0;
  logic [1:0] play_ch = '0;
  logic [DUR_W-1:0] play_dur = '0;
  logic play_ready, done, sound, tone_on;
  logic [9:0] frequency;

  tone_sequencer #(
    .N_CH(4), .FREQ_W(10), .TONE_TABLE({10'd587, 10'd523, 10'd494, 10'd440}),
    .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .DUR_W(DUR_W), .GAP_TICKS(GAP_TICKS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .led_color(led_color), .play_valid(play_valid),
    .play_ready(play_ready), .play_ch(play_ch), .play_dur(play_dur), .done(done),
    .sound(sound), .tone_on(tone_on), .frequency(frequency)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int tt [4] = '{440, 494, 523, 587};

  int m_pl, m_gl, m_pch, m_pdur, m_ch, m_age;
  logic m_acc;
  logic e_sound, e_on, e_done, e_ready;
  logic [9:0] e_freq;

  typedef struct {
    logic [3:0] led;
    int freq;
    logic on;
  } live_vec_t;

  live_vec_t lv [8] = '{
    '{4'b0110, 494, 1'b1}, '{4'b0001, 440, 1'b1}, '{4'b1000, 587, 1'b1},
    '{4'b1100, 523, 1'b1}, '{4'b0000, 0, 1'b0},   '{4'b1010, 494, 1'b1},
    '{4'b0101, 440, 1'b1}, '{4'b0000, 0, 1'b0}
  };

  int n, bad, on_cnt, rl, dn, dn_idx, r1, r2, fbad, nacc, ndone;
  int acc_at [4];
  int bch [3] = '{0, 3, 1};
  int bdur [3] = '{1, 0, 2};
  logic prev_s, prev_r, pending;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  function automatic int lowest(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_pl = 0; m_gl = 0; m_pch = 0; m_pdur = 0; m_ch = -1; m_age = 0; m_acc = 1'b0;
    e_sound = 1'b0; e_on = 1'b0; e_done = 1'b0; e_ready = 1'b1; e_freq = '0;
  endtask

  // one clock of the reference: busy time as remaining cycle counts, wave phase from tone age
  task automatic model_step();
    logic was_ready;
    int nc;
    was_ready = (m_pl == 0 && m_gl == 0);
    m_acc = was_ready && play_valid;
    e_done = 1'b0;
    if (m_pl > 0) begin
      m_pl--;
      if (m_pl == 0) begin
        e_done = 1'b1;
        m_gl = GAP_TICKS * DIV;
      end
    end else if (m_gl > 0) m_gl--;
    else if (play_valid) begin
      m_pl = (play_dur == 0) ? 1 : int'(play_dur) * DIV;
      m_pch = int'(play_ch);
      m_pdur = int'(play_dur);
    end
    nc = -1;
    if (m_pl > 0) nc = (m_pdur != 0) ? m_pch : -1;
    else if (was_ready && led_color != 0) nc = lowest(led_color);
    if (nc < 0) begin
      m_ch = -1;
      m_age = 0;
    end else if (nc != m_ch || m_acc) begin
      m_ch = nc;
      m_age = 0;
    end else m_age++;
    e_on = m_ch >= 0;
    e_freq = '0;
    e_sound = 1'b0;
    if (e_on) begin
      e_freq = 10'(tt[m_ch]);
      e_sound = ((m_age / (CLK_HZ / (2 * tt[m_ch]))) % 2) == 1;
    end
    e_ready = (m_pl == 0 && m_gl == 0);
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    @(negedge clk);
    chk("model", int'({sound, tone_on, done, play_ready, frequency}),
        int'({e_sound, e_on, e_done, e_ready, e_freq}));
  endtask

  task automatic run_len(input logic want, output int len);
    len = 0;
    while (sound == want && len < 2000) begin
      len++;
      tick();
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_sound", sound, 0);
    chk("rst_tone_on", tone_on, 0);
    chk("rst_done", done, 0);
    chk("rst_freq", frequency, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_ready", play_ready, 1);
    tick();

    for (int i = 0; i < 8; i++) begin
      led_color = lv[i].led;
      tick();
      chk("live_freq", frequency, lv[i].freq);
      chk("live_on", tone_on, lv[i].on);
      chk("live_ready", play_ready, 1);
    end

    led_color = 4'b0110;
    tick();
    chk("live_phase_freq", frequency, 494);
    chk("live_phase_start", sound, 0);
    run_len(1'b0, n);
    chk("live_low_run", n, 101);
    run_len(1'b1, n);
    chk("live_high_run", n, 101);
    led_color = '0;
    tick();
    chk("live_off", int'({sound, tone_on, frequency}), 0);
    tick();

    play_ch = 2'd2; play_dur = 12'd3; play_valid = 1'b1;
    tick();
    play_valid = 1'b0;
    on_cnt = 0; rl = 0; dn = 0; dn_idx = -1; r1 = -1; r2 = -1; fbad = 0; prev_s = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (tone_on) on_cnt++;
      if (!play_ready) rl++;
      if (done) begin dn++; dn_idx = i; end
      if (tone_on && frequency != 10'd523) fbad++;
      if (sound && !prev_s) begin
        if (r1 < 0) r1 = i;
        else if (r2 < 0) r2 = i;
      end
      prev_s = sound;
      tick();
    end
    chk("play_on_cycles", on_cnt, 300);
    chk("play_ready_low", rl, 500);
    chk("play_done_count", dn, 1);
    chk("play_done_at", dn_idx, 300);
    chk("play_freq_bad", fbad, 0);
    chk("play_first_rise", r1, 95);
    chk("play_period", r2 - r1, 190);
    chk("play_ready_back", play_ready, 1);

    led_color = 4'b0001;
    repeat (30) tick();
    chk("pre_live_freq", frequency, 440);
    play_ch = 2'd3; play_dur = 12'd1; play_valid = 1'b1;
    tick();
    play_valid = 1'b0;
    chk("pre_freq", frequency, 587);
    chk("pre_phase", sound, 0);
    n = 0;
    while (frequency != 10'd440 && n < 1000) begin
      tick();
      n++;
    end
    chk("pre_return_cycles", n, 301);
    chk("pre_return_phase", sound, 0);
    led_color = '0;
    tick();
    tick();

    play_ch = 2'd1; play_dur = 12'd0; play_valid = 1'b1;
    tick();
    play_valid = 1'b0;
    chk("zero_on", tone_on, 0);
    chk("zero_done_early", done, 0);
    chk("zero_ready", play_ready, 0);
    tick();
    chk("zero_done", done, 1);
    n = 1; bad = 0;
    while (!play_ready && n < 1000) begin
      tick();
      n++;
      if (tone_on || sound) bad++;
    end
    chk("zero_ready_cycles", n, 201);
    chk("zero_silent", bad, 0);

    nacc = 0; ndone = 0;
    play_ch = 2'(bch[0]); play_dur = 12'(bdur[0]); play_valid = 1'b1;
    for (int i = 0; i < 1400; i++) begin
      prev_r = play_ready;
      tick();
      if (prev_r && play_valid && nacc < 4) begin
        acc_at[nacc] = i;
        nacc++;
        if (nacc < 3) begin
          play_ch = 2'(bch[nacc]);
          play_dur = 12'(bdur[nacc]);
        end else play_valid = 1'b0;
      end
      if (done) ndone++;
    end
    play_valid = 1'b0;
    chk("b2b_accepts", nacc, 3);
    chk("b2b_dones", ndone, 3);
    chk("b2b_first", acc_at[0], 0);
    chk("b2b_second", acc_at[1], 301);
    chk("b2b_third", acc_at[2], 503);

    play_ch = 2'd0; play_dur = 12'd2; play_valid = 1'b1;
    tick();
    play_valid = 1'b0;
    repeat (150) tick();
    chk("mid_play_on", int'({tone_on, sound}), 3);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("mid_rst_out", int'({sound, tone_on, done, frequency}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("mid_rst_ready", play_ready, 1);
    chk("mid_rst_silent", tone_on, 0);

    pending = 1'b0;
    for (int i = 0; i < 15000; i++) begin
      if ($urandom_range(0, 49) == 0) led_color = 4'($urandom_range(0, 15));
      if (!pending && $urandom_range(0, 29) == 0) begin
        pending = 1'b1;
        play_ch = 2'($urandom_range(0, 3));
        play_dur = 12'($urandom_range(0, 3));
      end
      play_valid = pending;
      tick();
      if (m_acc) pending = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/tone_sequencer.md
Name: tone_sequencer

Overview:
- Parametrised successor to the fixed four-colour tone selector.
- Supports N_CH channels with a per-channel tone table and generates the audible square wave itself.
- Has two modes:
  - Live: follows the active LED/button bits.
  - Play: a handshake-driven timed note with a trailing silence gap, used by the game controller to play back the sequence.
- Sits between the game FSM/button decoder and the speaker pin.

Parameters:
- N_CH, 4, number of colour channels (≥2).
- FREQ_W, 10, width of tone frequency values in Hz.
- TONE_TABLE, {10'd587,10'd523,10'd494,10'd440}, packed N_CH*FREQ_W; channel i at bits [i*FREQ_W +: FREQ_W]; ch0=440.
- CLK_HZ, 50_000_000, clock frequency.
- TICK_HZ, 1000, duration unit rate (1 ms).
- DUR_W, 12, width of play duration in ticks.
- GAP_TICKS, 50, silence after each played note, in ticks (0 allowed).

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, asynchronous active-low reset.
- led_color, input, N_CH, live request bits; bit i = channel i.
- play_valid, input, 1, timed-note request.
- play_ready, output, 1, block can accept a request.
- play_ch, input, $clog2(N_CH), channel to play.
- play_dur, input, DUR_W, note length in ticks.
- done, output, 1, one-cycle pulse at end of a played note.
- sound, output, 1, square-wave speaker drive.
- tone_on, output, 1, a tone is currently being produced.
- frequency, output, FREQ_W, frequency of the current tone; 0 when silent.

Behaviour:
- Derived constants:
  - TICK_DIV = CLK_HZ/TICK_HZ.
  - HALF[i] = max(1, CLK_HZ/(2*TONE_TABLE[i])), computed at elaboration.
  - A table entry of 0 means a silent channel: tone_on=0, frequency=0.
- Reset (async, rst_n low): state=IDLE; sound, tone_on, done, frequency=0; all counters=0.
- play_ready = (state==IDLE || state==LIVE). It is 1 out of reset.
- States:
  - IDLE:
    - led_color!=0 → LIVE.
    - A handshake (play_valid && play_ready) → PLAY. This takes priority over led_color.
  - LIVE:
    - Channel = lowest set bit of led_color.
    - led_color==0 → IDLE.
    - A handshake → PLAY, preempting live.
  - PLAY:
    - Channel = latched play_ch.
    - Lasts exactly play_dur*TICK_DIV cycles.
    - The tick prescaler restarts at 0 on acceptance.
    - Then → GAP, with done=1 for that one cycle.
  - GAP:
    - Silent.
    - Lasts GAP_TICKS*TICK_DIV cycles, then → IDLE.
    - With GAP_TICKS=0: PLAY → IDLE directly, done still pulses.
    - led_color is ignored.
- Latency:
  - All outputs are registered.
  - frequency and tone_on update on the edge after the input or state change that causes them.
  - For an acceptance at edge k: tone_on=1 from edge k+1 through the last PLAY cycle.
- play_dur=0: PLAY lasts 1 cycle, silent (tone_on=0), done pulses, normal GAP follows.
- Wave generator:
  - Half-period counter counts 0..HALF[ch]-1; sound toggles at wrap.
  - On any change of active channel or tone start: counter=0, sound=0, so phase restarts from low.
  - When no tone is active: sound forced 0, counter held at 0.
- play_valid while not ready: ignored, no queuing; the requester holds it.
- led_color changes during PLAY/GAP have no effect. On entering IDLE, LIVE is re-entered the next cycle if bits are set.
- Counter widths: sized with $clog2 of the maximum count. No wrap-around occurs within legal parameter ranges.

Test Plan (CLK_HZ=100_000, TICK_HZ=1000 → TICK_DIV=100; HALF = 113/101/95/85; GAP_TICKS=2):
- Reset:
  - Stimulus: assert rst_n=0 mid-run (asynchronously, including mid-PLAY), then release.
  - Required response: sound/tone_on/done/frequency=0 immediately; after release, play_ready=1 and state IDLE.
- Live priority:
  - Stimulus: led_color=4'b0110.
  - Required response: next cycle frequency=494, tone_on=1; sound low 101 cycles, then toggles every 101.
  - Stimulus: then led_color=0.
  - Required response: next cycle all 0.
- Timed play:
  - Stimulus: play ch2, dur=3.
  - Required response: tone_on=1 for exactly 300 cycles; frequency=523; sound period 190 cycles; done single pulse; play_ready=0 for 300+200 cycles, then 1.
- Preemption:
  - Stimulus: led_color=4'b0001 live; then play ch3, dur=1.
  - Required response: frequency switches 440→587 with phase restart; after 100 cycles + gap, returns to 440 live.
- Zero duration:
  - Stimulus: play dur=0.
  - Required response: done pulses one cycle after acceptance; sound/tone_on stay 0; ready again after 200 cycles.
- Back-to-back:
  - Stimulus: play_valid held high with new ch/dur.
  - Required response: second accept only after the gap ends; no request is lost or duplicated.
